// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Machine-mode trap entry / mret control FSM for the CSR block.
//   Trap entry: flush and drain the pipeline, write mepc, mcause and mstatus
//   one per cycle over a single CSR write port, then redirect fetch to the
//   trap vector. mret: rewrite mstatus, then redirect fetch to mepc.
//
// Ports
//   clk, reset      core clock, asynchronous active-high reset
//   interrupt       enabled interrupt pending (level)
//   exception       synchronous exception at MEM (level)
//   int_code[4:0]   cause code of the current request
//   trap_pc[31:0]   trap vector target, already computed
//   epc_in[31:0]    PC to be saved into mepc
//   mret            mret at MEM
//   mepc_in[31:0]   current mepc value
//   mstatus_in[31:0] current mstatus value (sampled combinationally)
//   pipe_empty      nothing in flight behind MEM
//   stall / busy    FSM is not IDLE
//   flush           one-cycle flush pulse
//   csr_we, csr_sel[1:0], csr_wdata[31:0]   CSR write port (0 mepc, 1 mcause, 2 mstatus)
//   pc_redirect, pc_target[31:0]            one-cycle fetch redirect (target 0 otherwise)
//   drain_timeout   pulse when DRAIN gives up waiting for pipe_empty
//   dbg_state[2:0]  current FSM state, for observation only
//
// Handshake: there is no valid/ready pair here. Requests are levels sampled
// only while IDLE; everything seen while busy is ignored, and a still-pending
// level request is simply taken again once the FSM is back in IDLE.
//
// All outputs decode from the state register and the latched trap data, so
// they drop to 0 as soon as the asynchronous reset is asserted.
// DRAIN_MAX must be at least 1.

module trap_sequencer #(
  parameter int DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        exception,
  input  logic [4:0]  int_code,
  input  logic [31:0] trap_pc,
  input  logic [31:0] epc_in,
  input  logic        mret,
  input  logic [31:0] mepc_in,
  input  logic [31:0] mstatus_in,
  input  logic        pipe_empty,
  output logic        stall,
  output logic        flush,
  output logic        csr_we,
  output logic [1:0]  csr_sel,
  output logic [31:0] csr_wdata,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        busy,
  output logic        drain_timeout,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_W_EPC,
    S_W_CAUSE,
    S_W_STATUS,
    S_REDIRECT,
    S_RET_STATUS,
    S_RET_REDIRECT
  } state_t;

  state_t        state;
  logic [31:0]   epc_q;
  logic [31:0]   tpc_q;
  logic [31:0]   cause_q;
  logic [CW-1:0] drain_cnt;

  logic drain_done;
  assign drain_done = pipe_empty || (drain_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      epc_q     <= '0;
      tpc_q     <= '0;
      cause_q   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Exception wins over interrupt, both win over mret; losers are
          // dropped and only re-sampled on a later IDLE cycle.
          if (exception || interrupt) begin
            epc_q     <= epc_in;
            tpc_q     <= trap_pc;
            cause_q   <= {interrupt & ~exception, 26'b0, int_code};
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else if (mret) begin
            state <= S_RET_STATUS;
          end
        end
        S_DRAIN: begin
          // Counter saturates at CNT_MAX; reaching it forces the exit.
          if (drain_cnt != CNT_MAX) drain_cnt <= drain_cnt + 1'b1;
          if (drain_done) state <= S_W_EPC;
        end
        S_W_EPC:        state <= S_W_CAUSE;
        S_W_CAUSE:      state <= S_W_STATUS;
        S_W_STATUS:     state <= S_REDIRECT;
        S_REDIRECT:     state <= S_IDLE;
        S_RET_STATUS:   state <= S_RET_REDIRECT;
        S_RET_REDIRECT: state <= S_IDLE;
        default:        state <= S_IDLE;
      endcase
    end
  end

  // mstatus images for trap entry and mret.
  logic [31:0] status_trap;
  logic [31:0] status_ret;

  always_comb begin
    status_trap        = mstatus_in;
    status_trap[7]     = mstatus_in[3];  // MPIE <= MIE
    status_trap[3]     = 1'b0;           // MIE  <= 0
    status_trap[12:11] = 2'b11;          // MPP  <= M
    status_ret         = mstatus_in;
    status_ret[3]      = mstatus_in[7];  // MIE  <= MPIE
    status_ret[7]      = 1'b1;           // MPIE <= 1
    status_ret[12:11]  = 2'b11;
  end

  always_comb begin
    stall         = (state != S_IDLE);
    busy          = (state != S_IDLE);
    flush         = 1'b0;
    csr_we        = 1'b0;
    csr_sel       = 2'd0;
    csr_wdata     = '0;
    pc_redirect   = 1'b0;
    pc_target     = '0;
    drain_timeout = 1'b0;
    case (state)
      S_DRAIN: begin
        // The counter is 0 only on the first DRAIN cycle.
        flush         = (drain_cnt == '0);
        drain_timeout = (drain_cnt == CNT_MAX) && !pipe_empty;
      end
      S_W_EPC: begin
        csr_we    = 1'b1;
        csr_sel   = 2'd0;
        csr_wdata = epc_q & 32'hFFFF_FFFC;
      end
      S_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_sel   = 2'd1;
        csr_wdata = cause_q;
      end
      S_W_STATUS: begin
        csr_we    = 1'b1;
        csr_sel   = 2'd2;
        csr_wdata = status_trap;
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        pc_target   = tpc_q;
      end
      S_RET_STATUS: begin
        flush     = 1'b1;
        csr_we    = 1'b1;
        csr_sel   = 2'd2;
        csr_wdata = status_ret;
      end
      S_RET_REDIRECT: begin
        pc_redirect = 1'b1;
        pc_target   = mepc_in & 32'hFFFF_FFFC;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

  localparam int DRAIN_MAX = 15;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt, exception, mret, pipe_empty;
  logic [4:0]  int_code;
  logic [31:0] trap_pc, epc_in, mepc_in, mstatus_in;
  logic        stall, flush, csr_we, pc_redirect, busy, drain_timeout;
  logic [1:0]  csr_sel;
  logic [31:0] csr_wdata, pc_target;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  trap_sequencer #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .exception(exception),
    .int_code(int_code), .trap_pc(trap_pc), .epc_in(epc_in), .mret(mret),
    .mepc_in(mepc_in), .mstatus_in(mstatus_in), .pipe_empty(pipe_empty),
    .stall(stall), .flush(flush), .csr_we(csr_we), .csr_sel(csr_sel),
    .csr_wdata(csr_wdata), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .busy(busy), .drain_timeout(drain_timeout), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle output vector:
  // {stall, flush, csr_we, csr_sel, csr_wdata, pc_redirect, pc_target, busy, drain_timeout}
  logic [71:0] exp_q[$];

  function automatic logic [71:0] obs();
    return {stall, flush, csr_we, csr_sel, csr_wdata, pc_redirect, pc_target, busy, drain_timeout};
  endfunction

  function automatic logic [71:0] mk(logic st, logic fl, logic we, logic [1:0] sel,
                                     logic [31:0] wd, logic rd, logic [31:0] tgt, logic dt);
    return {st, fl, we, sel, wd, rd, tgt, st, dt};
  endfunction

  // ---------------- reference model ----------------
  // Trap: DRAIN lasts until pipe_empty (seen ea cycles after DRAIN starts)
  // or DRAIN_MAX+1 cycles, then three CSR writes and a redirect.
  task automatic model_trap(input logic is_int, input logic [4:0] code,
                            input logic [31:0] epc, input logic [31:0] tpc,
                            input logic [31:0] mst, input int ea);
    int d;
    logic to;
    logic [31:0] st;
    d  = ((ea < DRAIN_MAX) ? ea : DRAIN_MAX) + 1;
    to = (ea > DRAIN_MAX);
    st = mst;
    st[7] = mst[3];
    st[3] = 1'b0;
    st[12:11] = 2'b11;
    for (int i = 0; i < d; i++)
      exp_q.push_back(mk(1'b1, i == 0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, to && (i == d - 1)));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0, {epc[31:2], 2'b00}, 1'b0, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 2'd1, {is_int, 26'b0, code}, 1'b0, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 2'd2, st, 1'b0, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, tpc, 1'b0));
  endtask

  task automatic model_mret(input logic [31:0] mst, input logic [31:0] mepc);
    logic [31:0] st;
    st = mst;
    st[3] = mst[7];
    st[7] = 1'b1;
    st[12:11] = 2'b11;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd2, st, 1'b0, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, {mepc[31:2], 2'b00}, 1'b0));
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  // ---------------- drivers ----------------
  task automatic start_req(input logic exc, input logic intr, input logic mr,
                           input logic [4:0] code, input logic [31:0] epc,
                           input logic [31:0] tpc, input logic [31:0] mst,
                           input logic [31:0] mepc);
    @(posedge clk); #1;
    exception = exc; interrupt = intr; mret = mr; int_code = code;
    epc_in = epc; trap_pc = tpc; mstatus_in = mst; mepc_in = mepc;
    pipe_empty = 1'b0;
  endtask

  task automatic drive_cycle(input logic exc, input logic intr, input logic mr, input logic pe);
    @(posedge clk); #1;
    exception = exc; interrupt = intr; mret = mr; pipe_empty = pe;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    exception = 1'b1; interrupt = 1'b1; mret = 1'b1; pipe_empty = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs() !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs(), 72'h0);
    end
    @(posedge clk); #1;
    exception = 1'b0; interrupt = 1'b0; mret = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h expected %h", obs(), 72'h0);
    end
  endtask

  task automatic test_exception();
    logic [71:0] e;
    start_req(1'b1, 1'b0, 1'b0, 5'd2, 32'h100, 32'h8000_0000, 32'h8, 32'h0);
    model_trap(1'b0, 5'd2, 32'h100, 32'h8000_0000, 32'h8, 0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL exception_basic cycle %0d: got %h expected %h", k, obs(), e);
      end
    end
  endtask

  // ea: cycles after DRAIN entry at which pipe_empty rises
  task automatic test_drain(input int ea, input string name);
    logic [71:0] e;
    start_req(1'b0, 1'b1, 1'b0, 5'd7, 32'h444, 32'h8000_001C, 32'h0, 32'h0);
    model_trap(1'b1, 5'd7, 32'h444, 32'h8000_001C, 32'h0, ea);
    for (int k = 1; exp_q.size() > 0; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, k >= 1 + ea);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs(), e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [71:0] e;
    start_req(1'b1, 1'b1, 1'b0, 5'd4, 32'h2000, 32'h8000_0100, 32'h88, 32'h0);
    model_trap(1'b0, 5'd4, 32'h2000, 32'h8000_0100, 32'h88, 0);
    model_idle(1);
    model_trap(1'b1, 5'd4, 32'h2000, 32'h8000_0100, 32'h88, 0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      // interrupt held through the IDLE cycle after the first REDIRECT
      drive_cycle(1'b0, k <= 6, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL simultaneous cycle %0d: got %h expected %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_mret(input logic exc, input string name);
    logic [71:0] e;
    start_req(exc, 1'b0, 1'b1, 5'd11, 32'h3004, 32'h8000_0040, 32'h1880, 32'h203);
    if (exc) model_trap(1'b0, 5'd11, 32'h3004, 32'h8000_0040, 32'h1880, 0);
    else     model_mret(32'h1880, 32'h203);
    for (int k = 1; exp_q.size() > 0; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] e;
    start_req(1'b1, 1'b0, 1'b0, 5'd5, 32'h500, 32'h8000_0200, 32'h8, 32'h0);
    model_trap(1'b0, 5'd5, 32'h500, 32'h8000_0200, 32'h8, 0);
    for (int k = 1; k <= 3; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", k, obs(), e);
      end
    end
    exp_q.delete();
    // now in W_CAUSE: reset must clear outputs without waiting for a clock
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected %h", obs(), 72'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== 72'h0) begin
        n_fail++;
        $display("FAIL reset_mid_held %0d: got %h expected %h", k, obs(), 72'h0);
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    start_req(1'b1, 1'b0, 1'b0, 5'd13, 32'h607, 32'h8000_0300, 32'h0, 32'h0);
    model_trap(1'b0, 5'd13, 32'h607, 32'h8000_0300, 32'h0, 2);
    for (int k = 1; exp_q.size() > 0; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, k >= 3);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_mid_after cycle %0d: got %h expected %h", k, obs(), e);
      end
    end
  endtask

  // Random requests; request lines carry noise while busy, which must be ignored.
  task automatic test_random();
    logic [71:0] e;
    logic exc, intr, mr;
    logic [4:0] code;
    logic [31:0] epc, tpc, mst, mepc;
    int ea, gap, tlen;
    for (int t = 0; t < 25; t++) begin
      exc  = 1'($urandom_range(0, 1));
      intr = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 1));
      if (!exc && !intr) mr = 1'b1;
      code = 5'($urandom_range(0, 31));
      epc  = $urandom; tpc = $urandom; mst = $urandom; mepc = $urandom;
      ea   = $urandom_range(0, 18);
      gap  = $urandom_range(0, 2);
      start_req(exc, intr, mr, code, epc, tpc, mst, mepc);
      if (exc || intr) model_trap(intr & ~exc, code, epc, tpc, mst, ea);
      else             model_mret(mst, mepc);
      tlen = exp_q.size();
      model_idle(gap);
      for (int k = 1; exp_q.size() > 0; k++) begin
        if (k <= tlen)
          drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), k >= 1 + ea);
        else
          drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL random t%0d cycle %0d: got %h expected %h", t, k, obs(), e);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    interrupt = 1'b0; exception = 1'b0; mret = 1'b0; pipe_empty = 1'b0;
    int_code = '0; trap_pc = '0; epc_in = '0; mepc_in = '0; mstatus_in = '0;
    test_reset();
    test_exception();
    test_drain(100, "drain_timeout");
    test_drain(15, "drain_empty_at_max");
    test_drain(14, "drain_empty_before_max");
    test_drain(5, "drain_empty_mid");
    test_simultaneous();
    test_mret(1'b0, "mret_basic");
    test_reset_mid();
    test_mret(1'b1, "mret_vs_exception");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
